pdm_decimator: RTL

Receive-side counterpart of the team's first-order sigma-delta DAC. Takes a 1-bit pulse-density (sigma-delta) bitstream and recovers PCM samples with an order-N CIC (Hogenauer) decimation filter. Output is a 16-bit unsigned offset-binary sample, using the same coding as the DAC input. Used for loopback self-test of the DAC path and for external 1-bit ADC/PDM sources.

---
 rtl/pdm_decimator_pkg.sv | 34 +++
 rtl/pdm_decimator_cic_stage.sv | 32 +++
 rtl/pdm_decimator.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pdm_decimator_pkg.sv
// rtl/pdm_decimator_pkg.sv - shared widths, state encoding and scaling helpers for the PDM decimator
package pdm_decimator_pkg;

    localparam int PCM_MSBI = 15;
    localparam logic [PCM_MSBI:0] MIDSCALE = 16'(1 << PCM_MSBI);

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } dec_state_e;

    typedef enum logic {
        INTEGRATOR = 1'b0,
        COMB       = 1'b1
    } stage_kind_e;

    function automatic int cic_width(input int n, input int log2r);
        return n * log2r + 1;
    endfunction

    function automatic int cic_shift(input int n, input int log2r, input int msbi);
        return n * log2r - (msbi + 1);
    endfunction

    // A full-density frame lands exactly one LSB past the PCM range, so clamp it.
    function automatic logic [63:0] sat_shift(input logic [63:0] s, input int sh, input int msbi);
        logic [63:0] q;
        logic [63:0] lim;
        q   = s >> sh;
        lim = (64'd1 << (msbi + 1)) - 64'd1;
        return (q > lim) ? lim : q;
    endfunction

endpackage

// File: rtl/pdm_decimator_cic_stage.sv
// rtl/pdm_decimator_cic_stage.sv - one CIC integrator or comb stage with a shared W-bit register
module cic_stage
    import pdm_decimator_pkg::*;
#(
    parameter stage_kind_e KIND = INTEGRATOR,
    parameter int          W    = 19
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    logic [W-1:0] r;

    // Integrator y is the next accumulator value, so a cascade adds without per-stage delay.
    if (KIND == INTEGRATOR) begin : g_int
        assign y = r + x;
    end else begin : g_comb
        assign y = x - r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r <= '0;
        end else if (en) begin
            r <= (KIND == INTEGRATOR) ? y : x;
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// rtl/pdm_decimator.sv - order-N CIC decimator turning a PDM bitstream into offset-binary PCM
module pdm_decimator
    import pdm_decimator_pkg::*;
#(
    parameter int MSBI  = 15,
    parameter int LOG2R = 6,
    parameter int N     = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          PDMin,
    input  logic          PDMvalid,
    output logic [MSBI:0] PCMout,
    output logic          PCMvalid,
    input  logic          PCMready,
    output logic          Overrun
);

    localparam int W  = cic_width(N, LOG2R);
    localparam int SH = cic_shift(N, LOG2R, MSBI);

    logic [LOG2R-1:0] phase;
    logic             frame_end;
    logic             strobe;
    logic [W-1:0]     int_hold;
    logic [MSBI:0]    res;
    logic             res_valid;
    logic             deliver;
    dec_state_e       state;
    dec_state_e       state_nx;
    logic [2:0]       warm_cnt;
    logic [2:0]       warm_cnt_nx;

    assign frame_end = PDMvalid && (phase == '1);

    for (genvar k = 0; k < N; k++) begin : g_chain
        logic [W-1:0] integ_x;
        logic [W-1:0] integ_y;
        logic [W-1:0] comb_x;
        logic [W-1:0] comb_y;

        if (k == 0) begin : g_first
            assign integ_x = {{(W-1){1'b0}}, PDMin};
            assign comb_x  = int_hold;
        end else begin : g_next
            assign integ_x = g_chain[k-1].integ_y;
            assign comb_x  = g_chain[k-1].comb_y;
        end

        cic_stage #(.KIND(INTEGRATOR), .W(W)) u_integ (
            .clk   (Clk),
            .reset (Reset),
            .en    (PDMvalid),
            .x     (integ_x),
            .y     (integ_y)
        );

        cic_stage #(.KIND(COMB), .W(W)) u_comb (
            .clk   (Clk),
            .reset (Reset),
            .en    (strobe),
            .x     (comb_x),
            .y     (comb_y)
        );
    end

    // Frame-end integrator value is held so the combs see a stable input on the strobe cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase    <= '0;
            strobe   <= 1'b0;
            int_hold <= '0;
        end else begin
            strobe <= frame_end;
            if (PDMvalid) begin
                phase <= phase + 1'b1;
            end
            if (frame_end) begin
                int_hold <= g_chain[N-1].integ_y;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= WARMUP;
            warm_cnt <= '0;
        end else begin
            state    <= state_nx;
            warm_cnt <= warm_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        warm_cnt_nx = warm_cnt;
        deliver     = 1'b0;
        case (state)
            WARMUP: begin
                if (strobe) begin
                    if (warm_cnt == 3'(N - 1)) begin
                        state_nx    = RUN;
                        warm_cnt_nx = '0;
                    end else begin
                        warm_cnt_nx = warm_cnt + 3'd1;
                    end
                end
            end
            RUN: begin
                deliver = strobe;
            end
            default: begin
                state_nx = WARMUP;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            res       <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= deliver;
            if (deliver) begin
                res <= (MSBI + 1)'(sat_shift(64'(g_chain[N-1].comb_y), SH, MSBI));
            end
        end
    end

    // A same-cycle consume and load keeps PCMvalid high without flagging a loss.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PCMout   <= '0;
            PCMvalid <= 1'b0;
            Overrun  <= 1'b0;
        end else if (res_valid) begin
            PCMout   <= res;
            PCMvalid <= 1'b1;
            if (PCMvalid && !PCMready) begin
                Overrun <= 1'b1;
            end
        end else if (PCMvalid && PCMready) begin
            PCMvalid <= 1'b0;
        end
    end

endmodule
